level_alarm_monitor: RTL and testbench
======================================

// Module: level_alarm_monitor
// PURPOSE
//  Consumes the stored high/low thresholds and the measured level (0..100 %).
//  Drives an 8-segment thermometer LED bar (percent -> bar, the inverse of the
//  switch-bar -> percent mapping) and persistence-filtered high/low alarms with a
//  blinking alarm LED. Sits between the level sampler and the board LEDs.
// PARAMETERS
//  PERSIST_SAMPLES  4           consecutive valid samples beyond a threshold before alarm asserts (1..15)
//  HYST             2           percent hysteresis for alarm clear
//  BLINK_DIV        25_000_000  clk cycles per alarm_led half-period (0.25 s at 100 MHz)
// PORTS
//  clk_100MHz      in   1  system clock, 100 MHz
//  reset           in   1  synchronous, active-high reset
//  sample_valid    in   1  one-cycle strobe: level is a new sample
//  level           in   8  measured level, percent, legal 0..100
//  high_threshold  in   8  high alarm threshold, percent
//  low_threshold   in   8  low alarm threshold, percent
//  level_bar       out  8  thermometer bar, LSB-first fill
//  alarm_high      out  1  high alarm active
//  alarm_low       out  1  low alarm active
//  alarm_led       out  1  blinks while any alarm is active, else 0
//  level_error     out  1  last sample was out of range (>100)
// BEHAVIOUR
//  Reset (sync, 1 cycle suffices): level_bar=0, alarm_high=0, alarm_low=0, alarm_led=0,
//   level_error=0, FSM=NORMAL, persist count=0, blink counter=0.
//  All outputs registered; update on the clk edge after the sample_valid cycle (latency 1).
//  No sample_valid: all state holds (blink counter still runs).
//  Bar decode: segment k (k=0..7) lit iff level >= STEP[k], STEP={12,25,38,50,63,75,88,100};
//   0..11 -> 8'h00, 12 -> 8'h01, 50 -> 8'h0F, 100 -> 8'hFF.
//  level>100: level_error=1, level_bar and FSM/count unchanged. Next legal sample clears level_error.
//  Conditions per legal sample: HI = level>=high_threshold; LO = level<=low_threshold;
//   HI wins if both. HCLR = level <= sat0(high_threshold-HYST); LCLR = level >= min(low_threshold+HYST,100).
//  FSM states: NORMAL, PEND_HIGH, ALARM_HIGH, PEND_LOW, ALARM_LOW.
//   NORMAL: HI -> PEND_HIGH cnt=1; LO -> PEND_LOW cnt=1; else stay.
//   PEND_HIGH: HI -> cnt+1, on reaching PERSIST_SAMPLES -> ALARM_HIGH; LO -> PEND_LOW cnt=1; else -> NORMAL cnt=0.
//   PEND_LOW: mirror of PEND_HIGH.
//   ALARM_HIGH: HCLR -> NORMAL cnt=0; LO (threshold change) -> PEND_LOW cnt=1; else stay.
//   ALARM_LOW: LCLR -> NORMAL; HI -> PEND_HIGH cnt=1; else stay.
//   PERSIST_SAMPLES=1: NORMAL goes directly to ALARM_* on first qualifying sample.
//  alarm_high=1 only in ALARM_HIGH, alarm_low=1 only in ALARM_LOW; never both.
//  Thresholds are sampled only on sample_valid; changes mid-pending take effect next sample.
//  Blink: on entry to any ALARM state counter=0 and alarm_led=1; toggles every BLINK_DIV cycles;
//   forced 0 the cycle after leaving ALARM. Counter width = clog2(BLINK_DIV), no wrap glitch.
//  Arithmetic: 8-bit unsigned; HYST subtraction saturates at 0, addition at 100.
// STRUCTURE
//  Package level_meter_pkg: alarm state enum, STEP[0:7] table, LEVEL_MAX=100.
//  Sub-module level_to_bar: combinational percent -> 8-bit thermometer decoder.
//  Top: FSM + persist counter, blink divider, output registers.
// TESTING (PERSIST_SAMPLES=4, HYST=2, BLINK_DIV=8 for sim)
//  Bar sweep level 0,11,12,49,50,99,100 -> level_bar 00,00,01,07,0F,7F,FF one cycle after strobe.
//  high=80: 4 samples of 85 -> alarm_high=1 after 4th; 3 samples of 85 then 70 -> no alarm.
//  In ALARM_HIGH (high=80): level 79 -> stays; level 78 -> alarm_high=0, alarm_led=0 next cycle.
//  low=20: 4 samples of 20 -> alarm_low=1; then level 22 -> clears; alarm_led toggles every 8 clks while set.
//  level=150 strobe -> level_error=1, bar/alarms unchanged; next level=50 -> level_error=0, bar 0F.
//  Reset asserted during PEND_HIGH (cnt=3) -> all outputs 0; one more 85 sample does not alarm.

Source files
------------

// File: rtl/level_meter_pkg.sv
// level_meter_pkg: shared alarm states, bar step table and saturating helpers for the level alarm monitor
package level_meter_pkg;
   typedef enum logic [2:0] {NORMAL, PEND_HIGH, ALARM_HIGH, PEND_LOW, ALARM_LOW} alarm_state_e;
   localparam logic [7:0] LEVEL_MAX = 8'd100;
   localparam logic [7:0] STEP [8] = '{8'd12, 8'd25, 8'd38, 8'd50, 8'd63, 8'd75, 8'd88, 8'd100};
   function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
      return a > b ? a - b : 8'd0;
   endfunction
   function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s > {1'b0, LEVEL_MAX} ? LEVEL_MAX : s[7:0];
   endfunction
endpackage

// File: rtl/level_to_bar.sv
// level_to_bar: combinational percent to 8-segment LSB-first thermometer decoder
module level_to_bar
   import level_meter_pkg::*;
(
   input  logic [7:0] level,
   output logic [7:0] bar
);
   for (genvar k = 0; k < 8; k++) begin : g_seg
      assign bar[k] = level >= STEP[k];
   end
endmodule

// File: rtl/level_alarm_monitor.sv
// level_alarm_monitor: level to LED bar plus persistence-filtered high/low alarms with a blinking alarm LED
module level_alarm_monitor
   import level_meter_pkg::*;
#(
   parameter int PERSIST_SAMPLES = 4,
   parameter int HYST            = 2,
   parameter int BLINK_DIV       = 25_000_000
) (
   input  logic       clk_100MHz,
   input  logic       reset,
   input  logic       sample_valid,
   input  logic [7:0] level,
   input  logic [7:0] high_threshold,
   input  logic [7:0] low_threshold,
   output logic [7:0] level_bar,
   output logic       alarm_high,
   output logic       alarm_low,
   output logic       alarm_led,
   output logic       level_error
);
   localparam int CW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_DIV - 1);
   localparam logic [3:0] PERSIST = 4'(PERSIST_SAMPLES);
   alarm_state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d, hi_cnt, lo_cnt;
   logic [CW-1:0] blink_q, blink_d;
   logic [7:0] bar_q, bar_d, bar;
   logic err_q, err_d, led_q, led_d, hi, lo, hclr, lclr, in_alarm, entry, wrap;
   level_to_bar u_bar (.level(level), .bar(bar));
   always_comb begin
      hi = level >= high_threshold;
      lo = !hi && level <= low_threshold;
      hclr = level <= sat_sub(high_threshold, 8'(HYST));
      lclr = level >= sat_add(low_threshold, 8'(HYST));
      hi_cnt = state_q == PEND_HIGH ? cnt_q + 4'd1 : 4'd1;
      lo_cnt = state_q == PEND_LOW ? cnt_q + 4'd1 : 4'd1;
      state_d = state_q;
      cnt_d = cnt_q;
      bar_d = bar_q;
      err_d = err_q;
      if (sample_valid) begin
         err_d = level > LEVEL_MAX;
         if (!err_d) begin
            bar_d = bar;
            // Alarm states release on their hysteresis point; other states release when neither side qualifies
            if (state_q == ALARM_HIGH ? hclr : state_q == ALARM_LOW ? lclr : !hi && !lo) begin
               state_d = NORMAL;
               cnt_d = 4'd0;
            end else if (hi && state_q != ALARM_HIGH) begin
               cnt_d = hi_cnt;
               state_d = hi_cnt >= PERSIST ? ALARM_HIGH : PEND_HIGH;
            end else if (lo && state_q != ALARM_LOW) begin
               cnt_d = lo_cnt;
               state_d = lo_cnt >= PERSIST ? ALARM_LOW : PEND_LOW;
            end
         end
      end
      in_alarm = state_d == ALARM_HIGH || state_d == ALARM_LOW;
      entry = in_alarm && state_d != state_q;
      wrap = blink_q == BLINK_LAST;
      blink_d = (!in_alarm || entry || wrap) ? '0 : blink_q + CW'(1);
      led_d = in_alarm && (entry || (wrap ? !led_q : led_q));
   end
   always_ff @(posedge clk_100MHz) begin
      if (reset) begin
         state_q <= NORMAL;
         cnt_q <= 4'd0;
         blink_q <= '0;
         bar_q <= 8'd0;
         err_q <= 1'b0;
         led_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         blink_q <= blink_d;
         bar_q <= bar_d;
         err_q <= err_d;
         led_q <= led_d;
      end
   end
   assign level_bar = bar_q;
   assign alarm_high = state_q == ALARM_HIGH;
   assign alarm_low = state_q == ALARM_LOW;
   assign alarm_led = led_q;
   assign level_error = err_q;
endmodule

// File: tb/tb_level_alarm_monitor.sv
// tb_level_alarm_monitor: scoreboard bench with a run-length alarm model and blink-phase checking
module tb_level_alarm_monitor;
   localparam int P = 4, H = 2, BD = 8;
   logic clk_100MHz = 1'b0, reset = 1'b1, sample_valid = 1'b0;
   logic [7:0] level = 8'd0, high_threshold = 8'd80, low_threshold = 8'd20;
   logic [7:0] level_bar;
   logic alarm_high, alarm_low, alarm_led, level_error;
   level_alarm_monitor #(.PERSIST_SAMPLES(P), .HYST(H), .BLINK_DIV(BD)) dut (
      .clk_100MHz(clk_100MHz), .reset(reset), .sample_valid(sample_valid), .level(level),
      .high_threshold(high_threshold), .low_threshold(low_threshold), .level_bar(level_bar),
      .alarm_high(alarm_high), .alarm_low(alarm_low), .alarm_led(alarm_led), .level_error(level_error)
   );
   always #5 clk_100MHz = ~clk_100MHz;
   typedef struct {logic [7:0] bar; int alarm; logic err; bit entered;} exp_t;
   exp_t q[$];
   int checks = 0, errors = 0;
   int steps[8] = '{12, 25, 38, 50, 63, 75, 88, 100};
   int m_alarm = 0, m_run = 0;
   logic [7:0] m_bar = 8'd0;
   logic m_err = 1'b0;
   int cyc = 0, entry_cyc = 0, cur_alarm = 0;
   logic seen = 1'b0, rst_seen = 1'b0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   // m_run: signed length of the current qualifying run (+ high side, - low side); m_alarm: 0 none, 1 high, 2 low
   function automatic exp_t model(input int lvl, input int ht, input int lt);
      exp_t e;
      int prev, n;
      bit hi, lo, hclr, lclr;
      prev = m_alarm;
      n = 0;
      if (lvl > 100) m_err = 1'b1;
      else begin
         m_err = 1'b0;
         for (int k = 0; k < 8; k++) if (lvl >= steps[k]) n++;
         m_bar = 8'((1 << n) - 1);
         hi = lvl >= ht;
         lo = !hi && lvl <= lt;
         hclr = lvl <= (ht > H ? ht - H : 0);
         lclr = lvl >= (lt + H < 100 ? lt + H : 100);
         if (m_alarm == 1) begin
            if (hclr) begin m_alarm = 0; m_run = 0; end
            else if (lo) begin m_alarm = 0; m_run = -1; end
         end else if (m_alarm == 2) begin
            if (lclr) begin m_alarm = 0; m_run = 0; end
            else if (hi) begin m_alarm = 0; m_run = 1; end
         end else m_run = hi ? (m_run > 0 ? m_run + 1 : 1) : lo ? (m_run < 0 ? m_run - 1 : -1) : 0;
         if (m_alarm == 0) m_alarm = m_run >= P ? 1 : m_run <= -P ? 2 : 0;
      end
      e.bar = m_bar;
      e.alarm = m_alarm;
      e.err = m_err;
      e.entered = m_alarm != 0 && m_alarm != prev;
      return e;
   endfunction
   always @(posedge clk_100MHz) begin
      cyc <= cyc + 1;
      seen <= sample_valid && !reset;
      rst_seen <= reset;
   end
   always @(negedge clk_100MHz) begin
      if (cyc > 0) begin
         if (rst_seen) begin
            cur_alarm = 0;
            chk("reset_bar", level_bar, 0);
            chk("reset_alarm_high", alarm_high, 0);
            chk("reset_alarm_low", alarm_low, 0);
            chk("reset_led", alarm_led, 0);
            chk("reset_error", level_error, 0);
         end else begin
            if (seen) begin
               if (q.size() == 0) chk("unexpected_sample", 1, 0);
               else begin
                  exp_t e;
                  e = q.pop_front();
                  if (e.entered) entry_cyc = cyc;
                  cur_alarm = e.alarm;
                  chk("level_bar", level_bar, e.bar);
                  chk("alarm_high", alarm_high, e.alarm == 1);
                  chk("alarm_low", alarm_low, e.alarm == 2);
                  chk("level_error", level_error, e.err);
               end
            end
            chk("alarm_led", alarm_led, cur_alarm != 0 && ((cyc - entry_cyc) / BD) % 2 == 0);
         end
      end
   end
   task automatic send(input int lvl, input int ht, input int lt, input int gap);
      q.push_back(model(lvl, ht, lt));
      @(posedge clk_100MHz);
      #1;
      level = 8'(lvl);
      high_threshold = 8'(ht);
      low_threshold = 8'(lt);
      sample_valid = 1'b1;
      @(posedge clk_100MHz);
      #1;
      sample_valid = 1'b0;
      level = 8'($urandom_range(0, 255));
      repeat (gap) @(posedge clk_100MHz);
   endtask
   task automatic do_reset();
      @(posedge clk_100MHz);
      #1;
      reset = 1'b1;
      repeat (2) @(posedge clk_100MHz);
      #1;
      reset = 1'b0;
      m_alarm = 0;
      m_run = 0;
      m_bar = 8'd0;
      m_err = 1'b0;
   endtask
   initial begin
      int sweep[7] = '{0, 11, 12, 49, 50, 99, 100};
      int ht, lt, lvl, r;
      do_reset();
      foreach (sweep[i]) send(sweep[i], 255, 0, 1);
      do_reset();
      repeat (4) send(85, 80, 20, 0);
      send(79, 80, 20, 3);
      send(78, 80, 20, 2);
      repeat (3) send(85, 80, 20, 0);
      send(70, 80, 20, 1);
      repeat (4) send(20, 80, 20, 0);
      repeat (30) @(posedge clk_100MHz);
      send(21, 80, 20, 5);
      send(22, 80, 20, 2);
      send(150, 80, 20, 1);
      send(50, 80, 20, 1);
      repeat (3) send(85, 80, 20, 0);
      do_reset();
      send(85, 80, 20, 3);
      ht = 80;
      lt = 20;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 19) == 0) begin
            ht = $urandom_range(30, 100);
            lt = $urandom_range(0, 45);
         end
         r = $urandom_range(0, 9);
         lvl = r < 4 ? ht + int'($urandom_range(0, 6)) - 3 : r < 8 ? lt + int'($urandom_range(0, 6)) - 3 :
               r == 8 ? int'($urandom_range(0, 100)) : int'($urandom_range(101, 255));
         lvl = lvl < 0 ? 0 : lvl > 255 ? 255 : lvl;
         send(lvl, ht, lt, $urandom_range(0, 9) == 0 ? $urandom_range(5, 25) : $urandom_range(0, 2));
      end
      repeat (4) @(posedge clk_100MHz);
      chk("queue_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
